// File: rtl/dawg_domain_sched.sv
// dawg_domain_sched: round-robin time-sharing of one DAWG cacheline port.
// Optional macro DAWG_CONST_TIME_EN forces a reconfigure on every grant.
module dawg_domain_sched #(
  parameter int NUM_WAYS    = 4,
  parameter int ADDR_WIDTH  = 8,
  parameter int NUM_DOMAINS = 4,
  parameter int DOM_W       = $clog2(NUM_DOMAINS)
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic                              cfg_valid,
  input  logic [DOM_W-1:0]                  cfg_domain,
  input  logic [NUM_WAYS-1:0]               cfg_hitmap,
  output logic                              cfg_ready,
  input  logic [NUM_DOMAINS-1:0]            req_valid,
  input  logic [NUM_DOMAINS*ADDR_WIDTH-1:0] req_addr,
  output logic [NUM_DOMAINS-1:0]            req_ready,
  output logic                              resp_valid,
  output logic [DOM_W-1:0]                  resp_domain,
  output logic                              resp_hit,
  output logic                              os_req,
  output logic [NUM_WAYS-1:0]               hitmap,
  output logic                              user_req,
  output logic [ADDR_WIDTH-1:0]             addr,
  input  logic                              hit
);

  typedef enum logic [2:0] {
    IDLE,
    RECONF,
    ISSUE,
    WAIT,
    RESP
  } state_t;

  state_t state;

  logic [NUM_WAYS-1:0] dom_hitmap [NUM_DOMAINS];
  logic                loaded_valid;
  logic [DOM_W-1:0]    loaded_dom;
  logic [DOM_W-1:0]    rr_ptr;
  logic [DOM_W-1:0]    cur_dom;
  logic [DOM_W-1:0]    gnt_dom;
  logic [DOM_W-1:0]    idx;
  logic                gnt_found;
  logic                idle;
  logic                req_go;
  logic                need_reconf;

  // Descending scan so the closest set bit at or after rr_ptr wins.
  always_comb begin
    gnt_found = 1'b0;
    gnt_dom   = rr_ptr;
    idx       = '0;
    for (int i = NUM_DOMAINS - 1; i >= 0; i--) begin
      idx = rr_ptr + i[DOM_W-1:0];
      if (req_valid[idx]) begin
        gnt_found = 1'b1;
        gnt_dom   = idx;
      end
    end
  end

  assign idle      = (state == IDLE) && !reset;
  assign cfg_ready = idle && cfg_valid;
  assign req_go    = idle && !cfg_valid && gnt_found;
  assign req_ready = req_go ?
    ({{(NUM_DOMAINS-1){1'b0}}, 1'b1} << gnt_dom) :
    '0;

`ifdef DAWG_CONST_TIME_EN
  assign need_reconf = 1'b1;
`else
  assign need_reconf = !loaded_valid || (gnt_dom != loaded_dom);
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      loaded_valid <= 1'b0;
      loaded_dom   <= '0;
      rr_ptr       <= '0;
      cur_dom      <= '0;
      resp_valid   <= 1'b0;
      resp_domain  <= '0;
      resp_hit     <= 1'b0;
      os_req       <= 1'b0;
      hitmap       <= '0;
      user_req     <= 1'b0;
      addr         <= '0;
      for (int d = 0; d < NUM_DOMAINS; d++) begin
        dom_hitmap[d] <= '0;
      end
    end else begin
      os_req     <= 1'b0;
      user_req   <= 1'b0;
      resp_valid <= 1'b0;
      unique case (state)
        IDLE: begin
          if (cfg_valid) begin
            dom_hitmap[cfg_domain] <= cfg_hitmap;
            if (cfg_domain == loaded_dom) begin
              loaded_valid <= 1'b0;
            end
          end else if (gnt_found) begin
            cur_dom <= gnt_dom;
            addr    <= req_addr[gnt_dom*ADDR_WIDTH +: ADDR_WIDTH];
            rr_ptr  <= gnt_dom + 1'b1;
            if (need_reconf) begin
              state  <= RECONF;
              os_req <= 1'b1;
              hitmap <= dom_hitmap[gnt_dom];
            end else begin
              state    <= ISSUE;
              user_req <= 1'b1;
            end
          end
        end
        RECONF: begin
          loaded_dom   <= cur_dom;
          loaded_valid <= 1'b1;
          user_req     <= 1'b1;
          state        <= ISSUE;
        end
        ISSUE: begin
          state <= WAIT;
        end
        WAIT: begin
          resp_hit    <= hit;
          resp_domain <= cur_dom;
          resp_valid  <= 1'b1;
          state       <= RESP;
        end
        RESP: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dawg_domain_sched.sv
// tb_dawg_domain_sched: directed table plus corner sequences.
// Cacheline model reports a hit whenever the loaded hitmap is nonzero.
module tb_dawg_domain_sched;

  logic        clk = 1'b0;
  logic        reset;
  logic        cfg_valid;
  logic [1:0]  cfg_domain;
  logic [3:0]  cfg_hitmap;
  logic        cfg_ready;
  logic [3:0]  req_valid;
  logic [31:0] req_addr;
  logic [3:0]  req_ready;
  logic        resp_valid;
  logic [1:0]  resp_domain;
  logic        resp_hit;
  logic        os_req;
  logic [3:0]  hitmap;
  logic        user_req;
  logic [7:0]  addr;
  logic        hit;

`ifdef DAWG_CONST_TIME_EN
  localparam bit CT = 1'b1;
`else
  localparam bit CT = 1'b0;
`endif

  int total = 0;
  int bad   = 0;

  dawg_domain_sched dut (
    .clk        (clk),
    .reset      (reset),
    .cfg_valid  (cfg_valid),
    .cfg_domain (cfg_domain),
    .cfg_hitmap (cfg_hitmap),
    .cfg_ready  (cfg_ready),
    .req_valid  (req_valid),
    .req_addr   (req_addr),
    .req_ready  (req_ready),
    .resp_valid (resp_valid),
    .resp_domain(resp_domain),
    .resp_hit   (resp_hit),
    .os_req     (os_req),
    .hitmap     (hitmap),
    .user_req   (user_req),
    .addr       (addr),
    .hit        (hit)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (reset) hit <= 1'b0;
    else       hit <= user_req && (hitmap != 4'b0);
  end

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  always @(negedge clk) begin
    chk("excl_onehot",
        {30'd0, os_req & user_req, ~$onehot0(req_ready)}, 32'd0);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic cfg(input logic [1:0] d, input logic [3:0] hm);
    cfg_valid  = 1'b1;
    cfg_domain = d;
    cfg_hitmap = hm;
    @(negedge clk);
    chk("cfg_ready", {31'd0, cfg_ready}, 32'd1);
    tick();
    cfg_valid = 1'b0;
  endtask

  task automatic txn(input string nm, input logic [3:0] rv,
                     input logic [1:0] g, input bit sw,
                     input logic [3:0] hm, input logic [7:0] a,
                     input bit h);
    int os_k = 0;
    int us_k = 0;
    int rs_k = 0;
    logic [3:0] hm_s = '0;
    logic [7:0] a_s = '0;
    logic [1:0] d_s = '0;
    logic       h_s = 1'b0;
    bit exp_os;
    int exp_lat;
    exp_os  = sw | CT;
    exp_lat = exp_os ? 4 : 3;
    req_valid = rv;
    @(negedge clk);
    chk({nm, ".gnt"}, {28'd0, req_ready}, 32'd1 << g);
    tick();
    req_valid = 4'b0;
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      if (os_req && os_k == 0) os_k = k;
      if (user_req && us_k == 0) begin
        us_k = k;
        a_s  = addr;
        hm_s = hitmap;
      end
      if (resp_valid && rs_k == 0) begin
        rs_k = k;
        d_s  = resp_domain;
        h_s  = resp_hit;
      end
      tick();
    end
    chk({nm, ".os_cyc"}, os_k, exp_os ? 1 : 0);
    chk({nm, ".usr_cyc"}, us_k, exp_os ? 2 : 1);
    chk({nm, ".hitmap"}, {28'd0, hm_s}, {28'd0, hm});
    chk({nm, ".addr"}, {24'd0, a_s}, {24'd0, a});
    chk({nm, ".lat"}, rs_k, exp_lat);
    chk({nm, ".dom"}, {30'd0, d_s}, {30'd0, g});
    chk({nm, ".hit"}, {31'd0, h_s}, {31'd0, h});
  endtask

  typedef struct {
    logic [3:0] rv;
    logic [1:0] g;
    bit         sw;
    logic [3:0] hm;
    logic [7:0] a;
    bit         h;
  } vec_t;

  vec_t tbl[10];
  int   ord[5];

  initial begin
    reset      = 1'b1;
    cfg_valid  = 1'b0;
    cfg_domain = '0;
    cfg_hitmap = '0;
    req_valid  = '0;
    req_addr   = 32'hC4235A11;

    tbl[0] = '{4'b0010, 2'd1, 1'b1, 4'b0011, 8'h5A, 1'b1};
    tbl[1] = '{4'b0010, 2'd1, 1'b0, 4'b0011, 8'h5A, 1'b1};
    tbl[2] = '{4'b1111, 2'd2, 1'b1, 4'b0000, 8'h23, 1'b0};
    tbl[3] = '{4'b1111, 2'd3, 1'b1, 4'b1100, 8'hC4, 1'b1};
    tbl[4] = '{4'b1111, 2'd0, 1'b1, 4'b0001, 8'h11, 1'b1};
    tbl[5] = '{4'b1111, 2'd1, 1'b1, 4'b0011, 8'h5A, 1'b1};
    tbl[6] = '{4'b1111, 2'd2, 1'b1, 4'b0000, 8'h23, 1'b0};
    tbl[7] = '{4'b1111, 2'd3, 1'b1, 4'b1100, 8'hC4, 1'b1};
    tbl[8] = '{4'b1111, 2'd0, 1'b1, 4'b0001, 8'h11, 1'b1};
    tbl[9] = '{4'b0001, 2'd0, 1'b0, 4'b0001, 8'h11, 1'b1};
    ord = '{0, 1, 2, 3, 0};

    tick();
    tick();
    @(negedge clk);
    chk("reset_outs",
        {9'd0, cfg_ready, req_ready, resp_valid, resp_domain, resp_hit,
         os_req, hitmap, user_req, addr}, 32'd0);
    tick();
    reset = 1'b0;
    tick();

    cfg(2'd1, 4'b0011);
    cfg(2'd0, 4'b0001);
    cfg(2'd2, 4'b0000);
    cfg(2'd3, 4'b1100);

    for (int i = 0; i < 10; i++) begin
      txn($sformatf("v%0d", i), tbl[i].rv, tbl[i].g, tbl[i].sw,
          tbl[i].hm, tbl[i].a, tbl[i].h);
    end

    // Config to the loaded domain races a request and wins.
    cfg_valid  = 1'b1;
    cfg_domain = 2'd0;
    cfg_hitmap = 4'b1001;
    req_valid  = 4'b0001;
    @(negedge clk);
    chk("race.cfg_ready", {31'd0, cfg_ready}, 32'd1);
    chk("race.req_ready", {28'd0, req_ready}, 32'd0);
    tick();
    cfg_valid = 1'b0;
    txn("cfg_loaded", 4'b0001, 2'd0, 1'b1, 4'b1001, 8'h11, 1'b1);

    // Config arriving mid-transaction waits for IDLE.
    req_valid = 4'b0001;
    tick();
    req_valid  = 4'b0000;
    cfg_valid  = 1'b1;
    cfg_domain = 2'd3;
    cfg_hitmap = 4'b1111;
    @(negedge clk);
    chk("busy.cfg_ready", {31'd0, cfg_ready}, 32'd0);
    begin
      int w = 0;
      while (w < 8 && !cfg_ready) begin
        tick();
        @(negedge clk);
        w++;
      end
      chk("busy.cfg_eventually", {31'd0, cfg_ready}, 32'd1);
    end
    tick();
    cfg_valid = 1'b0;
    tick();

    // Reset during WAIT aborts the transaction.
    req_valid = 4'b0100;
    tick();
    req_valid = 4'b0000;
    tick();
    tick();
    reset = 1'b1;
    tick();
    @(negedge clk);
    chk("rst_wait.outs",
        {9'd0, cfg_ready, req_ready, resp_valid, resp_domain, resp_hit,
         os_req, hitmap, user_req, addr}, 32'd0);
    reset = 1'b0;
    tick();
    txn("post_rst", 4'b0010, 2'd1, 1'b1, 4'b0000, 8'h5A, 1'b0);

    // Held-high requests rotate from rr_ptr=0.
    reset = 1'b1;
    tick();
    reset = 1'b0;
    req_valid = 4'b1111;
    begin
      int n = 0;
      for (int k = 0; k < 30; k++) begin
        @(negedge clk);
        if (req_ready != 4'b0 && n < 5) begin
          chk($sformatf("rr.g%0d", n), {28'd0, req_ready},
              32'd1 << ord[n]);
          n++;
        end
        tick();
      end
      chk("rr.count", n, 5);
    end
    req_valid = 4'b0000;
    tick();
    tick();
    tick();
    tick();
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/dawg_domain_sched.md
Name: dawg_domain_sched

Overview:
- Time-shares one DAWG-partitioned cacheline port among NUM_DOMAINS security-domain requesters.
- Holds the OS-programmed per-domain way hitmaps.
- Arbitrates user requests round-robin and sequences the cacheline's os_req/hitmap reconfiguration before each user_req when the active domain changes.
- Sits between the domain request sources and the cacheline's os_req/hitmap/user_req/addr/hit interface.

Parameters:
- NUM_WAYS, 4: ways per set; width of every hitmap.
- ADDR_WIDTH, 8: request address width.
- NUM_DOMAINS, 4: number of requesting domains; must be a power of two and at least 2.
- DOM_W, $clog2(NUM_DOMAINS): domain index width.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- cfg_valid  in  1  OS hitmap write request
- cfg_domain  in  DOM_W  domain being configured
- cfg_hitmap  in  NUM_WAYS  new way mask for cfg_domain
- cfg_ready  out  1  config write accepted this cycle
- req_valid  in  NUM_DOMAINS  per-domain user request
- req_addr  in  NUM_DOMAINS*ADDR_WIDTH  flattened addresses; domain d occupies bits [d*ADDR_WIDTH +: ADDR_WIDTH]
- req_ready  out  NUM_DOMAINS  one-hot grant pulse
- resp_valid  out  1  response pulse
- resp_domain  out  DOM_W  domain of the response
- resp_hit  out  1  cacheline hit result
- os_req  out  1  to cacheline: load hitmap
- hitmap  out  NUM_WAYS  to cacheline: way mask
- user_req  out  1  to cacheline: lookup
- addr  out  ADDR_WIDTH  to cacheline: lookup address
- hit  in  1  from cacheline; valid the cycle after user_req

Behaviour:
- Reset (synchronous, active-high):
  - state=IDLE; all dom_hitmap regs = 0; loaded_valid=0; rr_ptr=0.
  - All outputs 0.
  - Reset asserted mid-transaction aborts it: no resp_valid is produced, and the cycle after reset deassertion is IDLE.
- FSM states: IDLE, RECONF, ISSUE, WAIT, RESP.
- IDLE, config path:
  - cfg_ready = cfg_valid.
  - Config has priority: if cfg_valid=1, req_ready=0 for all domains.
  - Write dom_hitmap[cfg_domain] <= cfg_hitmap.
  - If cfg_domain == loaded_dom, clear loaded_valid so the next request reconfigures.
  - Stay in IDLE.
- IDLE, request path (cfg_valid=0 and any req_valid set):
  - Grant g = first set req_valid at or after rr_ptr, modulo NUM_DOMAINS.
  - req_ready[g]=1 for this cycle only.
  - Latch g and its address; rr_ptr <= g+1, wrapping modulo NUM_DOMAINS.
  - Next state RECONF if !loaded_valid or g != loaded_dom, else ISSUE.
- RECONF (1 cycle):
  - os_req=1, hitmap=dom_hitmap[g].
  - loaded_dom<=g, loaded_valid<=1.
  - Next state ISSUE.
- ISSUE (1 cycle):
  - user_req=1, addr=latched address.
  - hitmap is held at the loaded value in every state except RECONF.
  - Next state WAIT.
- WAIT (1 cycle):
  - Sample hit into resp_hit; resp_domain <= g.
  - Next state RESP.
- RESP (1 cycle):
  - resp_valid=1; there is no backpressure.
  - Next state IDLE.
- Latency from grant cycle T to resp_valid:
  - Same domain as loaded: T+3.
  - Domain switch: T+4.
- Throughput: one outstanding request. req_ready is 0 in every non-IDLE state. cfg_ready is 0 outside IDLE, so cfg writes wait.
- Domain with hitmap 0: still serviced; os_req carries 0; resp_hit is whatever the cacheline returns (expected 0).
- Grant pulses are one-hot or zero at all times.
- os_req and user_req are never high in the same cycle.

Optional Feature:
- Macro: DAWG_CONST_TIME_EN.
- Defined:
  - RECONF is entered on every grant regardless of loaded_dom.
  - Latency is always T+4, independent of the previous domain, closing the switch-timing channel.
  - Config writes to the loaded domain still clear loaded_valid, which has no timing effect.
- Undefined: the RECONF bypass applies as specified in Behaviour.

Test Plan:
- Reset, then cfg (domain 1, hitmap 4'b0011), then req_valid=4'b0010 addr 8'h5A → os_req with hitmap 0011 at T+1, user_req with addr 5A at T+2, resp_valid with resp_domain=1 at T+4.
- Second request from domain 1 back-to-back after the previous resp → no os_req; resp_valid at T+3.
- req_valid=4'b1111 held high, rr_ptr=0 → grant order 0,1,2,3,0; each req_ready a single-cycle one-hot pulse.
- In IDLE, cfg_valid=1 simultaneous with req_valid=4'b0001 → cfg_ready=1, req_ready=0; grant on the following cycle. A cfg to the loaded domain forces os_req on that domain's next request.
- reset asserted during WAIT → no resp_valid; all outputs 0 next cycle; dom_hitmaps cleared; the first subsequent request performs RECONF.
- With DAWG_CONST_TIME_EN defined, repeat the second scenario → os_req asserted and resp_valid at T+4.
